// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one fixed-latency unified instruction/data memory between
//            the multicycle CPU (port C) and the DMA/program-loader (port D).
//            Every access runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE.
//            When both ports request at once, arbitration is round-robin.
// Ports    : clk, reset               clock, synchronous active-high reset
//            c_req/c_we/c_addr/c_wd   CPU request, held until c_ready
//            c_ready, c_rd            CPU completion pulse, registered read data
//            d_*                      same set for the DMA port
//            m_en, m_we               memory enable / single-cycle write strobe
//            m_addr, m_wd             latched address / write data of grantee
//            m_rd                     memory read data (valid in last ACCESS cycle)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  // CPU port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wd,
  output logic          c_ready,
  output logic [DW-1:0] c_rd,
  // DMA port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wd,
  output logic          d_ready,
  output logic [DW-1:0] d_rd,
  // Memory side
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic       PORT_C   = 1'b0;
  localparam logic       PORT_D   = 1'b1;
  // Counter is loaded so that it reaches zero in the MEM_LAT-th ACCESS cycle.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            gnt_q;
  logic            last_q;
  logic            we_q;
  logic            c_ready_q;
  logic            d_ready_q;
  logic [DW-1:0]   c_rd_q;
  logic [DW-1:0]   d_rd_q;
  logic            m_en_q;
  logic            m_we_q;
  logic [AW-1:0]   m_addr_q;
  logic [DW-1:0]   m_wd_q;

  logic            any_req_d;
  logic            gnt_d;

  // Port chosen if a grant happens this cycle. On a tie the port that did not
  // win last time goes first, so neither port waits more than one access.
  always_comb begin
    any_req_d = c_req | d_req;
    gnt_d     = PORT_C;
    if (c_req && d_req) begin
      gnt_d = ~last_q;
    end else if (d_req) begin
      gnt_d = PORT_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      gnt_q     <= PORT_C;
      last_q    <= PORT_D;
      we_q      <= 1'b0;
      c_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      c_rd_q    <= '0;
      d_rd_q    <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wd_q    <= '0;
    end else begin
      // Ready and write strobe are single-cycle pulses by construction.
      c_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      m_we_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            gnt_q  <= gnt_d;
            last_q <= gnt_d;
            // Requester inputs are captured once here and never looked at
            // again until the next IDLE cycle.
            if (gnt_d == PORT_D) begin
              m_addr_q <= d_addr;
              m_wd_q   <= d_wd;
              we_q     <= d_we;
              m_we_q   <= d_we;
            end else begin
              m_addr_q <= c_addr;
              m_wd_q   <= c_wd;
              we_q     <= c_we;
              m_we_q   <= c_we;
            end
            m_en_q  <= 1'b1;
            cnt_q   <= CNT_INIT;
            state_q <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (cnt_q == 4'd0) begin
            m_en_q  <= 1'b0;
            state_q <= ST_DONE;
            if (gnt_q == PORT_D) begin
              d_ready_q <= 1'b1;
              if (!we_q) begin
                d_rd_q <= m_rd;
              end
            end else begin
              c_ready_q <= 1'b1;
              if (!we_q) begin
                c_rd_q <= m_rd;
              end
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          m_en_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign c_ready = c_ready_q;
  assign d_ready = d_ready_q;
  assign c_rd    = c_rd_q;
  assign d_rd    = d_rd_q;
  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wd    = m_wd_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Random CPU/DMA traffic is
//            scored against a transaction-level schedule model; directed
//            sequences cover reset mid-access, address change after grant,
//            and the MEM_LAT=1 / MEM_LAT=15 builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wd, d_addr, d_wd;
  logic        c_ready, d_ready, m_en, m_we;
  logic [31:0] c_rd, d_rd, m_addr, m_wd, m_rd;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
    .c_ready(c_ready), .c_rd(c_rd),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_ready(d_ready), .d_rd(d_rd),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd)
  );

  // ---------------- memory behind the main DUT ----------------
  function automatic logic [31:0] seed(input int idx);
    return 32'h5EED_0000 ^ (32'(idx) * 32'h0103_0507);
  endfunction

  logic [31:0] phys [64];
  logic [63:0] wr_mask = '0;
  int          en_run  = 0;

  always @(posedge clk) begin
    en_run <= m_en ? en_run + 1 : 0;
    if (m_we) begin
      phys[m_addr[7:2]]    <= m_wd;
      wr_mask[m_addr[7:2]] <= 1'b1;
    end
  end

  // Data is only valid in the LAT-th enabled cycle; garbage otherwise.
  always_comb begin
    m_rd = 32'hBAD0_0000 | 32'(en_run);
    if (m_en && en_run == LAT - 1)
      m_rd = wr_mask[m_addr[7:2]] ? phys[m_addr[7:2]] : seed(int'(m_addr[7:2]));
  end

  // ---------------- MEM_LAT=1 and MEM_LAT=15 builds ----------------
  logic        x_req, x_lo;
  logic [31:0] x_addr, x_lo32;
  logic        x1_c_ready, x1_d_ready, x1_m_en, x1_m_we;
  logic [31:0] x1_c_rd, x1_d_rd, x1_m_addr, x1_m_wd, x1_m_rd;
  logic        x15_c_ready, x15_d_ready, x15_m_en, x15_m_we;
  logic [31:0] x15_c_rd, x15_d_rd, x15_m_addr, x15_m_wd, x15_m_rd;
  int          run1 = 0, run15 = 0;

  always @(posedge clk) begin
    run1  <= x1_m_en  ? run1 + 1  : 0;
    run15 <= x15_m_en ? run15 + 1 : 0;
  end
  assign x1_m_rd  = (x1_m_en  && run1  == 0)  ? 32'h1111_0001 : 32'h0BAD_0001;
  assign x15_m_rd = (x15_m_en && run15 == 14) ? 32'h1515_000F : 32'h0BAD_000F;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .c_req(x_req), .c_we(x_lo), .c_addr(x_addr), .c_wd(x_lo32),
    .c_ready(x1_c_ready), .c_rd(x1_c_rd),
    .d_req(x_lo), .d_we(x_lo), .d_addr(x_lo32), .d_wd(x_lo32),
    .d_ready(x1_d_ready), .d_rd(x1_d_rd),
    .m_en(x1_m_en), .m_we(x1_m_we), .m_addr(x1_m_addr), .m_wd(x1_m_wd), .m_rd(x1_m_rd)
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(15)) dut_l15 (
    .clk(clk), .reset(reset),
    .c_req(x_req), .c_we(x_lo), .c_addr(x_addr), .c_wd(x_lo32),
    .c_ready(x15_c_ready), .c_rd(x15_c_rd),
    .d_req(x_lo), .d_we(x_lo), .d_addr(x_lo32), .d_wd(x_lo32),
    .d_ready(x15_d_ready), .d_rd(x15_d_rd),
    .m_en(x15_m_en), .m_we(x15_m_we), .m_addr(x15_m_addr), .m_wd(x15_m_wd), .m_rd(x15_m_rd)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] ref_mem [64];
  int          next_free = 0;
  int          c_at = -1, d_at = -1;
  int          en_lo = -1, en_hi = -2, we_cyc = -1;
  int          c_start = 0, d_start = 0;
  logic        c_out = 1'b0, d_out = 1'b0;
  logic        c_isw = 1'b0, d_isw = 1'b0;
  logic        last_d = 1'b1;
  logic        ex_we = 1'b0;
  logic [31:0] ex_addr = '0, ex_wd = '0;
  logic [31:0] pend_c = '0, pend_d = '0, exp_c_rd = '0, exp_d_rd = '0;

  task automatic model_step(input int cyc);
    logic        en_exp, pick_d, we;
    logic [31:0] a, wd;
    if (cyc == c_at) begin
      if (!c_isw) exp_c_rd = pend_c;
      c_out = 1'b0;
    end
    if (cyc == d_at) begin
      if (!d_isw) exp_d_rd = pend_d;
      d_out = 1'b0;
    end
    en_exp = (cyc >= en_lo) && (cyc <= en_hi);
    check("c_ready", 32'(c_ready), 32'(cyc == c_at));
    check("d_ready", 32'(d_ready), 32'(cyc == d_at));
    check("m_en",    32'(m_en),    32'(en_exp));
    check("m_we",    32'(m_we),    32'(cyc == we_cyc));
    if (en_exp) begin
      check("m_addr", m_addr, ex_addr);
      if (ex_we) check("m_wd", m_wd, ex_wd);
    end
    check("c_rd", c_rd, exp_c_rd);
    check("d_rd", d_rd, exp_d_rd);

    if (cyc >= next_free && (c_req || d_req)) begin
      pick_d  = (c_req && d_req) ? !last_d : d_req;
      last_d  = pick_d;
      a       = pick_d ? d_addr : c_addr;
      wd      = pick_d ? d_wd   : c_wd;
      we      = pick_d ? d_we   : c_we;
      ex_addr = a;
      ex_wd   = wd;
      ex_we   = we;
      en_lo   = cyc + 1;
      en_hi   = cyc + LAT;
      we_cyc  = we ? cyc + 1 : -1;
      next_free = cyc + LAT + 2;
      if (pick_d) begin
        d_at  = cyc + LAT + 1;
        d_isw = we;
        if (!we) pend_d = ref_mem[a[7:2]];
        check("d_wait_bound", 32'(cyc - d_start <= LAT + 2), 32'd1);
      end else begin
        c_at  = cyc + LAT + 1;
        c_isw = we;
        if (!we) pend_c = ref_mem[a[7:2]];
        check("c_wait_bound", 32'(cyc - c_start <= LAT + 2), 32'd1);
      end
      if (we) ref_mem[a[7:2]] = wd;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2);
  endfunction

  // Requesters hold their transaction until its ready, then may issue a new
  // one straight away (p_new percent chance per idle cycle).
  task automatic drive_next(input int cyc_next, input int p_new);
    if (!c_out) begin
      if ($urandom_range(0, 99) < p_new) begin
        c_out = 1'b1; c_req = 1'b1; c_we = 1'($urandom_range(0, 1));
        c_addr = rand_addr(); c_wd = $urandom; c_start = cyc_next;
      end else c_req = 1'b0;
    end
    if (!d_out) begin
      if ($urandom_range(0, 99) < p_new) begin
        d_out = 1'b1; d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = rand_addr(); d_wd = $urandom; d_start = cyc_next;
      end else d_req = 1'b0;
    end
  endtask

  // Directed CPU read; optionally changes the CPU inputs right after grant.
  task automatic cpu_read(input logic [31:0] a, input bit scramble);
    int lat, en_cnt;
    c_req = 1'b1; c_we = 1'b0; c_addr = a; c_wd = 32'hFFFF_FFFF;
    en_cnt = 0;
    @(posedge clk); #1;
    if (scramble) begin c_addr = a + 32'h4; c_we = 1'b1; c_wd = 32'h0; end
    lat = 1;
    while (!c_ready && lat < 40) begin
      if (m_en) begin
        en_cnt++;
        check("rd_maddr", m_addr, a);
        check("rd_no_we", 32'(m_we), 32'd0);
      end
      @(posedge clk); #1;
      lat++;
    end
    c_req = 1'b0; c_we = 1'b0;
    check("rd_latency", 32'(lat), 32'(LAT + 1));
    check("rd_en_cycles", 32'(en_cnt), 32'(LAT));
    check("rd_data", c_rd, ref_mem[a[7:2]]);
    @(posedge clk); #1;
    check("rd_ready_width", 32'(c_ready), 32'd0);
  endtask

  initial begin
    int lat1, lat15;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
    reset = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wd = '0;
    x_req = 1'b0; x_lo = 1'b0; x_addr = 32'h40; x_lo32 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_c_ready", 32'(c_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_c_rd",    c_rd,   32'd0);
    check("rst_d_rd",    d_rd,   32'd0);
    check("rst_m_en",    32'(m_en), 32'd0);
    check("rst_m_we",    32'(m_we), 32'd0);
    check("rst_m_addr",  m_addr, 32'd0);
    check("rst_m_wd",    m_wd,   32'd0);

    @(posedge clk); #1;
    reset = 1'b0;
    drive_next(0, 40);
    // Sparse traffic, then continuous contention on both ports, then drain.
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk);
      model_step(cyc);
      @(posedge clk); #1;
      drive_next(cyc + 1, (cyc < 600) ? 40 : ((cyc < 1100) ? 100 : 0));
    end

    // Reset during the 2nd ACCESS cycle of a CPU read aborts it silently.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; c_req = 1'b0;
    check("rstmid_m_en",    32'(m_en),    32'd0);
    check("rstmid_m_we",    32'(m_we),    32'd0);
    check("rstmid_c_ready", 32'(c_ready), 32'd0);
    check("rstmid_c_rd",    c_rd,         32'd0);
    check("rstmid_m_addr",  m_addr,       32'd0);
    @(posedge clk); #1;
    check("rstmid_c_ready2", 32'(c_ready), 32'd0);

    cpu_read(32'h40, 1'b0);
    cpu_read(32'h40, 1'b1);
    cpu_read(32'h8C, 1'b0);

    // MEM_LAT = 1 and 15: ready 2 and 16 cycles after the request cycle.
    x_req = 1'b1;
    lat1 = 0; lat15 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 1) x_req = 1'b0;
      if (x1_c_ready  && lat1  == 0) lat1  = k;
      if (x15_c_ready && lat15 == 0) lat15 = k;
    end
    check("lat1_latency",  32'(lat1),  32'd2);
    check("lat15_latency", 32'(lat15), 32'd16);
    check("lat1_data",     x1_c_rd,    32'h1111_0001);
    check("lat15_data",    x15_c_rd,   32'h1515_000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
